// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, control states and status flags.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_AND = 4'b0001,
    OP_OR  = 4'b0010,
    OP_GTU = 4'b0011,
    OP_XOR = 4'b0100,
    OP_MUL = 4'b0101,
    OP_SLL = 4'b0110,
    OP_EQ  = 4'b1000,
    OP_GTS = 4'b1011,
    OP_SRL = 4'b1100,
    OP_SRA = 4'b1110,
    OP_SUB = 4'b1111
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// done_o pulses for one cycle after WIDTH iterations while prod_o holds the product.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               last;

  assign last = (cnt_q == CW'(WIDTH));

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (last) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && last;
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops land on the accept
// edge, MUL takes WIDTH+1 cycles. Results are frozen while the consumer stalls.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   c_hi_q, c_hi_d;
  flags_t             flags_q, flags_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   res;
  flags_t             res_flags;
  logic               accept;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] prod;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = a - b;
  assign shamt  = b[SHW-1:0];
  assign accept = in_valid && in_ready;

  always_comb begin
    res       = '0;
    res_flags = '0;
    case (sel)
      OP_ADD: begin
        res             = sum[WIDTH-1:0];
        res_flags.carry = sum[WIDTH];
        res_flags.ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res             = diff;
        res_flags.carry = (a >= b);
        res_flags.ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_EQ:  res = (a == b) ? '1 : '0;
      OP_GTU: res = (a > b) ? '1 : '0;
      OP_GTS: res = ($signed(a) > $signed(b)) ? '1 : '0;
      OP_SLL: res = a << shamt;
      OP_SRL: res = a >> shamt;
      OP_SRA: res = $signed(a) >>> shamt;
      default: res = '0;
    endcase
    res_flags.zero = (res == '0);
  end

  // MUL is started here but its result is written only when the iterator reports done.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    c_hi_d      = c_hi_q;
    flags_d     = flags_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (sel == OP_MUL) begin
            mul_start   = 1'b1;
            state_d     = ST_MUL;
            out_valid_d = 1'b0;
          end else begin
            c_d         = res;
            c_hi_d      = '0;
            flags_d     = res_flags;
            out_valid_d = 1'b1;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          c_d           = prod[WIDTH-1:0];
          c_hi_d        = prod[2*WIDTH-1:WIDTH];
          flags_d.zero  = (prod[WIDTH-1:0] == '0);
          flags_d.carry = 1'b0;
          flags_d.ovf   = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      c_hi_q      <= '0;
      flags_q     <= '{zero: 1'b1, carry: 1'b0, ovf: 1'b0};
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      c_hi_q      <= c_hi_d;
      flags_q     <= flags_d;
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  assign in_ready  = (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign c_hi      = c_hi_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c, c_hi;
  logic        zero, carry, ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] c;
    logic [31:0] c_hi;
    logic        zero;
    logic        carry;
    logic        ovf;
  } exp_t;

  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .c_hi      (c_hi),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    longint      sx, sy, t;
    logic [63:0] u;
    int          k;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    k  = int'(y % 32);
    r  = '{c: 32'h0, c_hi: 32'h0, zero: 1'b0, carry: 1'b0, ovf: 1'b0};
    case (s)
      4'h0: begin
        u = 64'(x) + 64'(y);
        r.c = u[31:0];
        r.carry = (u > 64'hFFFF_FFFF);
        t = sx + sy;
        r.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'hF: begin
        r.c = x - y;
        r.carry = (x >= y);
        t = sx - sy;
        r.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'h1: r.c = x & y;
      4'h2: r.c = x | y;
      4'h4: r.c = x ^ y;
      4'h8: r.c = (x == y) ? 32'hFFFF_FFFF : 32'h0;
      4'h3: r.c = (x > y) ? 32'hFFFF_FFFF : 32'h0;
      4'hB: r.c = (sx > sy) ? 32'hFFFF_FFFF : 32'h0;
      4'h6: begin u = 64'(x) * (64'd1 << k); r.c = u[31:0]; end
      4'hC: begin u = 64'(x) / (64'd1 << k); r.c = u[31:0]; end
      4'hE: begin t = sx >>> k; r.c = t[31:0]; end
      4'h5: begin u = 64'(x) * 64'(y); r.c = u[31:0]; r.c_hi = u[63:32]; end
      default: r.c = 32'h0;
    endcase
    r.zero = (r.c == 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, " c"}, 64'(c), 64'(e.c));
    chk({tag, " c_hi"}, 64'(c_hi), 64'(e.c_hi));
    chk({tag, " zero"}, 64'(zero), 64'(e.zero));
    chk({tag, " carry"}, 64'(carry), 64'(e.carry));
    chk({tag, " ovf"}, 64'(ovf), 64'(e.ovf));
  endtask

  // Issue one op with out_ready high, measure latency, compare against the model.
  task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] cobs);
    exp_t e;
    int   cyc;
    int   lat;
    e = model(s, x, y);
    sel = s; a = x; b = y; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, " accepted"}, 64'(cyc < 100), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (s == 4'h5) chk({tag, " in_ready low in MUL"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, 64'(lat), (s == 4'h5) ? 64'd33 : 64'd0);
    chk_out(tag, e);
    cobs = c;
  endtask

  localparam int ND = 13;
  localparam logic [3:0]  DSEL [ND] = '{4'h0, 4'h0, 4'hF, 4'hB, 4'h3, 4'hE, 4'hC, 4'h6,
                                        4'h5, 4'h8, 4'h1, 4'h7, 4'h2};
  localparam logic [31:0] DA   [ND] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFF,
                                        32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd1,
                                        32'hFFFF_FFFF, 32'h1234, 32'hF0F0, 32'd5, 32'hF0};
  localparam logic [31:0] DB   [ND] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'd31, 32'd31,
                                        32'd32, 32'd2, 32'h1234, 32'hFF00, 32'd6, 32'h0F};
  localparam logic [31:0] DC   [ND] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0,
                                        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1,
                                        32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hF000, 32'h0, 32'hFF};

  initial begin
    logic [31:0] cobs;
    logic [3:0]  s;
    exp_t        e;
    int          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sel = '0;
    #3;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset c", 64'(c), 64'd0);
    chk("reset c_hi", 64'(c_hi), 64'd0);
    chk("reset zero", 64'(zero), 64'd1);
    chk("reset carry", 64'(carry), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < ND; i++) begin
      run_op($sformatf("dir%0d", i), DSEL[i], DA[i], DB[i], cobs);
      chk($sformatf("dir%0d const c", i), 64'(cobs), 64'(DC[i]));
    end
    @(posedge clk); #1;
    chk("drain out_valid", 64'(out_valid), 64'd0);

    // Backpressure: ADD held for four cycles while an XOR waits at the input.
    out_ready = 1'b0;
    sel = 4'h0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    sel = 4'h4; a = 32'hF0; b = 32'hFF;
    chk("bp first valid", 64'(out_valid), 64'd1);
    chk("bp first c", 64'(c), 64'd3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d c", i), 64'(c), 64'd3);
      chk($sformatf("bp hold%0d in_ready", i), 64'(in_ready), 64'd0);
      chk($sformatf("bp hold%0d out_valid", i), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp xor valid", 64'(out_valid), 64'd1);
    chk("bp xor c", 64'(c), 64'h0F);
    @(posedge clk); #1;
    chk("bp no duplicate", 64'(out_valid), 64'd0);

    // Reset five cycles into a MUL.
    sel = 4'h5; a = 32'd7; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midmul out_valid", 64'(out_valid), 64'd0);
    chk("midmul in_ready", 64'(in_ready), 64'd1);
    chk("midmul c", 64'(c), 64'd0);
    chk("midmul zero", 64'(zero), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midmul no stale result", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), pick(), pick(), cobs);
    end

    // Back-to-back single-cycle ops: one result per cycle.
    for (int i = 0; i < 8; i++) begin
      s = 4'($urandom_range(0, 15));
      if (s == 4'h5) s = 4'h0;
      sel = s; a = pick(); b = pick(); in_valid = 1'b1;
      e = model(s, a, b);
      chk($sformatf("burst%0d in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("burst%0d valid", i), 64'(out_valid), 64'd1);
      chk_out($sformatf("burst%0d", i), e);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("burst end drained", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the datapath's combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with status flags.
- Single-cycle ops take one cycle; MUL uses an iterative shift-add multiplier.
- Sits between the decode stage and the register-file writeback, with backpressure on both sides.

Parameters:
- WIDTH, 32, operand and result width in bits (≥ 8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  4  opcode.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- c  out  WIDTH  result, low WIDTH bits.
- c_hi  out  WIDTH  MUL upper half; 0 for all other ops.
- zero  out  1  c == 0.
- carry  out  1  ADD carry-out / SUB no-borrow (a >= b unsigned); 0 otherwise.
- ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.

Behaviour:
- Reset (async, any state) forces: state=IDLE, out_valid=0, c=0, c_hi=0, zero=1, carry=0, ovf=0, MUL counter=0.
- Any in-flight MUL is discarded on reset.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready; a, b and sel are captured on that edge.
- Opcodes:
  - 0000 ADD.
  - 1111 SUB (a - b, two's complement).
  - 0001 AND.
  - 0010 OR.
  - 0100 XOR.
  - 1000 EQ: all-ones if a==b, else 0.
  - 0011 GTU: all-ones if a>b unsigned, else 0.
  - 0110 SLL by b[SHW-1:0].
  - 1100 SRL by b[SHW-1:0].
  - 1110 SRA by b[SHW-1:0] (new).
  - 1011 GTS: signed greater-than, all-ones/0 (new).
  - 0101 MUL: unsigned, full 2*WIDTH product split into c_hi:c.
  - Any other opcode: c=0, flags computed on that value (zero=1). It is not an error.
- Single-cycle ops: result registered on the accept edge; out_valid=1 from the next cycle. Latency 1.
- Full throughput of one op per cycle when out_ready is held high.
- MUL FSM, states IDLE -> MUL -> IDLE:
  - On accept, load multiplicand, multiplier and a zeroed accumulator; counter=0; go to MUL.
  - In MUL, each cycle: if the multiplier LSB is set, add the shifted multiplicand; shift; counter++.
  - After WIDTH iterations, write c/c_hi/zero, set out_valid=1 and return to IDLE.
  - Latency from the accept edge to out_valid is WIDTH+1 cycles.
  - in_ready=0 throughout MUL.
- Output hold:
  - While out_valid && !out_ready, c/c_hi/flags are frozen and in_ready=0.
  - out_valid clears on the out_ready edge unless a new accept occurs on the same edge.
  - Simultaneous accept and drain is legal and gives back-to-back results.
  - For MUL, out_valid drops on drain and rises again after WIDTH+1 cycles.
- Width rules:
  - ADD carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - ADD ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - SUB ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
- Shift boundary: shift amount WIDTH-1 is legal. Upper bits of b beyond SHW are ignored (b=WIDTH behaves as shift 0).
- in_valid while in_ready=0 is ignored; the producer must hold its request.

Decomposition:
- Package alu_pkg holds:
  - the opcode enum (OP_ADD..OP_MUL, OP_SRA, OP_GTS);
  - the FSM state enum (ST_IDLE, ST_MUL);
  - a flags struct {zero, carry, ovf}.
- Sub-module alu_mul_iter (start/busy/done, WIDTH-parametrised shift-add) is natural.
- Single-cycle ops stay in the top-level combinational case feeding the output registers.

Test Plan:
- Reset mid-MUL: assert rst 5 cycles into MUL 7*9 -> out_valid=0, in_ready=1, c=0, zero=1 immediately (async). No stale result appears afterwards.
- WIDTH=32, ADD a=FFFF_FFFF, b=1 -> c=0, zero=1, carry=1, ovf=0. Then ADD 7FFF_FFFF+1 -> c=8000_0000, ovf=1, carry=0.
- SUB 3-5 -> c=FFFF_FFFE, carry=0, ovf=0. GTS a=FFFF_FFFF, b=1 -> c=0. GTU with the same operands -> c=FFFF_FFFF.
- SRA a=8000_0000, b=31 -> c=FFFF_FFFF. SRL with the same operands -> c=1. SLL a=1, b=32 -> c=1 (amount wraps to 0).
- MUL a=FFFF_FFFF, b=2 -> out_valid exactly 33 cycles after accept, c=FFFF_FFFE, c_hi=1. in_ready=0 throughout.
- Backpressure: out_ready=0 for 4 cycles after ADD 1+2 -> c stays 3, in_ready=0. Raise out_ready with in_valid/XOR F0^FF pending -> next cycle c=0F, with no result lost or duplicated.
